// File: rtl/ps2_receiver_if.sv
// ps2_receiver_if: PS/2 pin inputs and decoded scan-code outputs of the receiver.
interface ps2_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       break_o;
    logic       ext_o;
    logic       err_o;
    modport master (output ps2_clk, ps2_data, input code_o, code_valid_o, break_o, ext_o, err_o);
    modport slave (input ps2_clk, ps2_data, output code_o, code_valid_o, break_o, ext_o, err_o);
endinterface

// File: rtl/ps2_receiver.sv
// ps2_receiver: synchronizes and filters a PS/2 device clock, deframes 11-bit frames
// and reports scan codes with F0 (break) and E0 (extended) prefixes folded into flags.
module ps2_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 14780
) (
    input logic           clk_i,
    input logic           reset,
    ps2_receiver_if.slave bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]    clk_s, dat_s;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic [1:0]    state;
    logic [3:0]    bcnt;
    logic [8:0]    sh;
    logic [TW-1:0] tcnt;
    logic          brk_p, ext_p;
    logic          stb, dat, good;

    assign stb  = filt_d & ~filt;
    assign dat  = dat_s[1];
    assign good = (^sh) & dat;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            clk_s  <= 2'b11;
            dat_s  <= 2'b11;
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            clk_s  <= {clk_s[0], bus.ps2_clk};
            dat_s  <= {dat_s[0], bus.ps2_data};
            filt_d <= filt;
            if (clk_s[1] == filt)
                fcnt <= '0;
            else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s[1];
                fcnt <= '0;
            end else
                fcnt <= fcnt + 1'b1;
        end
    end

    // Frame verdict is taken on the stop-bit strobe so registered outputs land in the CHECK cycle.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            bcnt             <= '0;
            sh               <= '0;
            tcnt             <= '0;
            brk_p            <= 1'b0;
            ext_p            <= 1'b0;
            bus.code_o       <= 8'h00;
            bus.code_valid_o <= 1'b0;
            bus.break_o      <= 1'b0;
            bus.ext_o        <= 1'b0;
            bus.err_o        <= 1'b0;
        end else begin
            bus.code_valid_o <= 1'b0;
            bus.err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (stb && !dat) begin
                        state <= RECV;
                        bcnt  <= '0;
                    end
                end
                RECV: begin
                    if (stb) begin
                        tcnt <= '0;
                        sh   <= {dat, sh[8:1]};
                        bcnt <= bcnt + 1'b1;
                        if (bcnt == 4'd9) begin
                            state <= CHECK;
                            if (!good) begin
                                bus.err_o <= 1'b1;
                                brk_p     <= 1'b0;
                                ext_p     <= 1'b0;
                            end else if (sh[7:0] == 8'hF0)
                                brk_p <= 1'b1;
                            else if (sh[7:0] == 8'hE0)
                                ext_p <= 1'b1;
                            else begin
                                bus.code_o       <= sh[7:0];
                                bus.break_o      <= brk_p;
                                bus.ext_o        <= ext_p;
                                bus.code_valid_o <= 1'b1;
                                brk_p            <= 1'b0;
                                ext_p            <= 1'b0;
                            end
                        end
                    // err_o is registered, so fire one cycle early to land TIMEOUT_CYC after the strobe.
                    end else if (tcnt == TW'(TIMEOUT_CYC - 2)) begin
                        state     <= IDLE;
                        tcnt      <= '0;
                        bus.err_o <= 1'b1;
                        brk_p     <= 1'b0;
                        ext_p     <= 1'b0;
                    end else
                        tcnt <= tcnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    bcnt  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: directed PS/2 frames with hand-computed scan codes, flags and latencies.
module tb_ps2_receiver;
    localparam int FL = 8;
    localparam int TO = 500;
    localparam int H  = 40;

    logic clk_i = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0, fall_cyc = 0, vcyc = 0, ecyc = 0;
    int   nv = 0, ne = 0, nboth = 0, total = 0, bad = 0;
    int   v0, e0;

    ps2_receiver_if bus ();

    ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
        .clk_i (clk_i),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (bus.code_valid_o) begin nv++; vcyc = cyc; end
        if (bus.err_o) begin ne++; ecyc = cyc; end
        if (bus.code_valid_o && bus.err_o) nboth++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par, input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            if (glitch) begin
                repeat (15) @(negedge clk_i);
                bus.ps2_clk = 1'b0;
                repeat (FL - 1) @(negedge clk_i);
                bus.ps2_clk = 1'b1;
                repeat (H - 15 - (FL - 1)) @(negedge clk_i);
            end else
                repeat (H) @(negedge clk_i);
            bus.ps2_clk = 1'b0;
            fall_cyc = cyc;
            repeat (H) @(negedge clk_i);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        repeat (30) @(negedge clk_i);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_code", bus.code_o, 8'h00);
        chk("rst_valid", bus.code_valid_o, 1'b0);
        chk("rst_break", bus.break_o, 1'b0);
        chk("rst_ext", bus.ext_o, 1'b0);
        chk("rst_err", bus.err_o, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge clk_i);

        v0 = nv; e0 = ne;
        send(8'h1C, 1'b0, 11, 1'b0);
        chk("1c_nvalid", nv - v0, 1);
        chk("1c_code", bus.code_o, 8'h1C);
        chk("1c_break", bus.break_o, 1'b0);
        chk("1c_ext", bus.ext_o, 1'b0);
        chk("1c_latency", vcyc - fall_cyc, 11);
        chk("1c_nerr", ne - e0, 0);

        v0 = nv; e0 = ne;
        send(8'hE0, 1'b0, 11, 1'b0);
        send(8'hF0, 1'b0, 11, 1'b0);
        chk("pfx_nvalid", nv - v0, 0);
        send(8'h75, 1'b0, 11, 1'b0);
        chk("75_nvalid", nv - v0, 1);
        chk("75_code", bus.code_o, 8'h75);
        chk("75_break", bus.break_o, 1'b1);
        chk("75_ext", bus.ext_o, 1'b1);
        chk("75_nerr", ne - e0, 0);

        v0 = nv; e0 = ne;
        send(8'hF0, 1'b0, 11, 1'b0);
        send(8'h1C, 1'b1, 11, 1'b0);
        chk("par_nerr", ne - e0, 1);
        chk("par_nvalid", nv - v0, 0);
        chk("par_hold", bus.code_o, 8'h75);
        send(8'h1C, 1'b0, 11, 1'b0);
        chk("par_next_code", bus.code_o, 8'h1C);
        chk("par_next_break", bus.break_o, 1'b0);

        v0 = nv; e0 = ne;
        send(8'h00, 1'b0, 5, 1'b0);
        repeat (TO + 40) @(negedge clk_i);
        chk("to_nerr", ne - e0, 1);
        chk("to_when", ecyc - fall_cyc, 10 + TO);
        chk("to_nvalid", nv - v0, 0);
        send(8'h29, 1'b0, 11, 1'b0);
        chk("29_code", bus.code_o, 8'h29);
        chk("29_nvalid", nv - v0, 1);
        chk("29_nerr", ne - e0, 1);

        v0 = nv; e0 = ne;
        send(8'h1C, 1'b0, 11, 1'b1);
        chk("glitch_code", bus.code_o, 8'h1C);
        chk("glitch_nvalid", nv - v0, 1);
        chk("glitch_nerr", ne - e0, 0);

        v0 = nv; e0 = ne;
        send(8'h33, 1'b0, 7, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("mid_rst_code", bus.code_o, 8'h00);
        reset = 1'b0;
        repeat (20) @(negedge clk_i);
        send(8'h5A, 1'b0, 11, 1'b0);
        chk("5a_nvalid", nv - v0, 1);
        chk("5a_code", bus.code_o, 8'h5A);
        chk("5a_break", bus.break_o, 1'b0);
        chk("5a_nerr", ne - e0, 0);

        chk("valid_err_overlap", nboth, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
